ram_march_bist: RTL

- Memory built-in self-test initiator for the team's single-port block RAM. Drives the RAM's en/wen/addr/datai port and checks its datao.
- Runs a March C- sequence over every address, then reports pass/fail plus first-failure diagnostics.
- Sits beside each RAM instance. The system muxes RAM access to this block while busy=1.

---
 rtl/ram_bist_pkg.sv | 39 +++
 rtl/ram_bist_cmp.sv | 65 ++++++
 rtl/ram_march_bist.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ram_bist_pkg.sv
// Shared encodings for the March C- RAM BIST: element codes, FSM states, per-element op table.
// Pure definitions; no logic, latency or flow control.
package ram_bist_pkg;

    typedef logic [2:0] elem_t;

    localparam elem_t ELEM_E0 = 3'd0;
    localparam elem_t ELEM_E1 = 3'd1;
    localparam elem_t ELEM_E2 = 3'd2;
    localparam elem_t ELEM_E3 = 3'd3;
    localparam elem_t ELEM_E4 = 3'd4;
    localparam elem_t ELEM_E5 = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic rd_en;
        logic exp_ones;
        logic wr_en;
        logic wr_ones;
        logic descending;
    } elem_cfg_t;

    // E1..E4 read first then write back the complement at the same address.
    localparam elem_cfg_t ELEM_TABLE [6] = '{
        '{rd_en: 1'b0, exp_ones: 1'b0, wr_en: 1'b1, wr_ones: 1'b0, descending: 1'b0},
        '{rd_en: 1'b1, exp_ones: 1'b0, wr_en: 1'b1, wr_ones: 1'b1, descending: 1'b0},
        '{rd_en: 1'b1, exp_ones: 1'b1, wr_en: 1'b1, wr_ones: 1'b0, descending: 1'b0},
        '{rd_en: 1'b1, exp_ones: 1'b0, wr_en: 1'b1, wr_ones: 1'b1, descending: 1'b1},
        '{rd_en: 1'b1, exp_ones: 1'b1, wr_en: 1'b1, wr_ones: 1'b0, descending: 1'b1},
        '{rd_en: 1'b1, exp_ones: 1'b0, wr_en: 1'b0, wr_ones: 1'b0, descending: 1'b0}
    };

endpackage

// File: rtl/ram_bist_cmp.sv
// Read-compare stage: registers each issued read's expectation, compares against ram_datao next cycle.
// Latency 1 cycle from read issue to mismatch; no backpressure, captures only the first failure.
module ram_bist_cmp
    import ram_bist_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              rd_vld,
    input  logic [DWIDTH-1:0] rd_exp,
    input  logic [AWIDTH-1:0] rd_addr,
    input  elem_t             rd_elem,
    input  logic [DWIDTH-1:0] ram_datao,
    output logic              mismatch,
    output logic              fail_seen,
    output elem_t             fail_elem,
    output logic [AWIDTH-1:0] fail_addr,
    output logic [DWIDTH-1:0] fail_exp,
    output logic [DWIDTH-1:0] fail_got
);

    logic              vld_q;
    logic [DWIDTH-1:0] exp_q;
    logic [AWIDTH-1:0] addr_q;
    elem_t             elem_q;

    assign mismatch = vld_q && (ram_datao != exp_q) && !fail_seen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q     <= 1'b0;
            exp_q     <= '0;
            addr_q    <= '0;
            elem_q    <= ELEM_E0;
            fail_seen <= 1'b0;
            fail_elem <= ELEM_E0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
        end else if (clr) begin
            vld_q     <= 1'b0;
            fail_seen <= 1'b0;
            fail_elem <= ELEM_E0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
        end else begin
            vld_q  <= rd_vld;
            exp_q  <= rd_exp;
            addr_q <= rd_addr;
            elem_q <= rd_elem;
            if (mismatch) begin
                fail_seen <= 1'b1;
                fail_elem <= elem_q;
                fail_addr <= addr_q;
                fail_exp  <= exp_q;
                fail_got  <= ram_datao;
            end
        end
    end

endmodule

// File: rtl/ram_march_bist.sv
// March C- BIST initiator for a single-port RAM: one op per cycle, 10*MEMDEPTH ops, done 2 cycles after last read.
// No backpressure; start is ignored while busy, and the first mismatch stops issue after the in-flight op.
module ram_march_bist
    import ram_bist_pkg::*;
#(
    parameter int DWIDTH   = 8,
    parameter int AWIDTH   = 8,
    parameter int MEMDEPTH = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [2:0]        fail_elem,
    output logic [AWIDTH-1:0] fail_addr,
    output logic [DWIDTH-1:0] fail_exp,
    output logic [DWIDTH-1:0] fail_got,
    output logic              ram_en,
    output logic              ram_wen,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_datai,
    input  logic [DWIDTH-1:0] ram_datao
);

    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(MEMDEPTH - 1);
    localparam logic [DWIDTH-1:0] ONES      = '1;

    state_t            state, state_nxt;
    elem_t             cur_elem, elem_nxt, elem_inc;
    logic              en_nxt, wen_nxt, pass_nxt;
    logic [AWIDTH-1:0] addr_nxt;
    logic [DWIDTH-1:0] datai_nxt;
    logic              at_term, to_write, clr;
    logic              mismatch, fail_seen;
    logic [DWIDTH-1:0] rd_exp;

    assign busy     = (state == ST_RUN) || (state == ST_DRAIN);
    assign done     = (state == ST_DONE);
    assign elem_inc = cur_elem + 3'd1;
    assign at_term  = ELEM_TABLE[cur_elem].descending ? (ram_addr == '0) : (ram_addr == LAST_ADDR);
    // The op on the bus is the read half of a read/write pair: its write comes next.
    assign to_write = ram_en && !ram_wen && ELEM_TABLE[cur_elem].wr_en;
    assign rd_exp   = ELEM_TABLE[cur_elem].exp_ones ? ONES : '0;

    always_comb begin
        state_nxt = state;
        elem_nxt  = cur_elem;
        en_nxt    = ram_en;
        wen_nxt   = ram_wen;
        addr_nxt  = ram_addr;
        datai_nxt = ram_datai;
        pass_nxt  = pass;
        clr       = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    clr       = 1'b1;
                    pass_nxt  = 1'b0;
                    elem_nxt  = ELEM_E0;
                    en_nxt    = 1'b1;
                    wen_nxt   = 1'b1;
                    addr_nxt  = '0;
                    datai_nxt = '0;
                end
            end
            ST_RUN: begin
                if (mismatch || (!to_write && at_term && cur_elem == ELEM_E5)) begin
                    state_nxt = mismatch ? ST_DONE : ST_DRAIN;
                    pass_nxt  = 1'b0;
                    en_nxt    = 1'b0;
                    wen_nxt   = 1'b0;
                    addr_nxt  = '0;
                    datai_nxt = '0;
                end else begin
                    en_nxt = 1'b1;
                    if (to_write) begin
                        wen_nxt   = 1'b1;
                        datai_nxt = ELEM_TABLE[cur_elem].wr_ones ? ONES : '0;
                    end else if (at_term) begin
                        elem_nxt  = elem_inc;
                        addr_nxt  = ELEM_TABLE[elem_inc].descending ? LAST_ADDR : '0;
                        wen_nxt   = !ELEM_TABLE[elem_inc].rd_en;
                        datai_nxt = (wen_nxt && ELEM_TABLE[elem_inc].wr_ones) ? ONES : '0;
                    end else begin
                        addr_nxt  = ELEM_TABLE[cur_elem].descending ? ram_addr - 1'b1 : ram_addr + 1'b1;
                        wen_nxt   = !ELEM_TABLE[cur_elem].rd_en;
                        datai_nxt = (wen_nxt && ELEM_TABLE[cur_elem].wr_ones) ? ONES : '0;
                    end
                end
            end
            ST_DRAIN: begin
                state_nxt = ST_DONE;
                pass_nxt  = !mismatch;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cur_elem  <= ELEM_E0;
            ram_en    <= 1'b0;
            ram_wen   <= 1'b0;
            ram_addr  <= '0;
            ram_datai <= '0;
            pass      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur_elem  <= elem_nxt;
            ram_en    <= en_nxt;
            ram_wen   <= wen_nxt;
            ram_addr  <= addr_nxt;
            ram_datai <= datai_nxt;
            pass      <= pass_nxt;
        end
    end

    ram_bist_cmp #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_cmp (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .rd_vld    (ram_en && !ram_wen),
        .rd_exp    (rd_exp),
        .rd_addr   (ram_addr),
        .rd_elem   (cur_elem),
        .ram_datao (ram_datao),
        .mismatch  (mismatch),
        .fail_seen (fail_seen),
        .fail_elem (fail_elem),
        .fail_addr (fail_addr),
        .fail_exp  (fail_exp),
        .fail_got  (fail_got)
    );

endmodule
